// File: rtl/decode_sequencer.sv
// decode_sequencer
// Multi-cycle control FSM for the MERC-16 core. It walks each instruction
// through START/FETCH/DECODE/EXEC/MEM/WB and drives the DecodeSubsystem,
// ALU, PC, IR and memory strobes. It waits on the memory ready handshake.
//
// Optional feature: define MEM_TIMEOUT_EN to enable a memory wait timeout.
// When MemReady stays low for MEM_TIMEOUT cycles in FETCH or MEM, busError_o
// sets (sticky until reset) and the FSM enters HALT.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_i           asynchronous active-high reset
//   opcode_i[4:0]   IR[15:11], sampled in DECODE
//   zero_i          ALU zero flag, valid in EXEC
//   memReady_i      memory ack for the current read or write
//   irWrite_o       load IR from memory
//   pcWrite_o       load PC
//   pcSrc_o[1:0]    0=PC+1, 1=PC+SE, 2=jump immediate
//   memRead_o       memory read request
//   memWrite_o      memory write request
//   memAddrSrc_o    0=PC, 1=ALU result
//   aluSrc_o        0=B, 1=SE
//   aluOp_o[2:0]    ALU function
//   writeEnable_o, regDest_o[1:0], regData_o[1:0], rsRd_o[1:0], rsRt_o,
//   upperLower_o    DecodeSubsystem controls
//   illegalOp_o     one-cycle pulse on an undefined opcode
//   halted_o        high in HALT
//   busError_o      sticky timeout flag (0 unless MEM_TIMEOUT_EN)
module decode_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] opcode_i,
  input  logic       zero_i,
  input  logic       memReady_i,
  output logic       irWrite_o,
  output logic       pcWrite_o,
  output logic [1:0] pcSrc_o,
  output logic       memRead_o,
  output logic       memWrite_o,
  output logic       memAddrSrc_o,
  output logic       aluSrc_o,
  output logic [2:0] aluOp_o,
  output logic       writeEnable_o,
  output logic [1:0] regDest_o,
  output logic [1:0] regData_o,
  output logic [1:0] rsRd_o,
  output logic       rsRt_o,
  output logic       upperLower_o,
  output logic       illegalOp_o,
  output logic       halted_o,
  output logic       busError_o
);

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    K_RTYPE, K_ADDI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_HALT, K_ILL
  } kind_t;

  state_t     state_q, state_d;
  logic [4:0] opcode_q;
  kind_t      kindNow, kindQ;

  function automatic kind_t classify(input logic [4:0] op);
    kind_t k;
    if (op[4:3] == 2'b00) begin
      k = K_RTYPE;
    end else begin
      case (op)
        5'h08:   k = K_ADDI;
        5'h09:   k = K_LUI;
        5'h0A:   k = K_LW;
        5'h0B:   k = K_SW;
        5'h0C:   k = K_BEQ;
        5'h0D:   k = K_J;
        5'h0E:   k = K_JAL;
        5'h1F:   k = K_HALT;
        default: k = K_ILL;
      endcase
    end
    return k;
  endfunction

  // DECODE dispatches on the live opcode; later states use the latched copy
  assign kindNow = classify(opcode_i);
  assign kindQ   = classify(opcode_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_START;
      opcode_q <= 5'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= opcode_i;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  logic [3:0] waitCnt_q, waitCnt_d;
  logic       busError_q, busError_d;
  logic       waiting;
  logic       timeout;

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !memReady_i;
  // The cycle that would bring the count to MEM_TIMEOUT is the last wait cycle
  assign timeout = waiting && (waitCnt_q == TIMEOUT_LAST);

  // Counter restarts whenever the state changes, so every FETCH/MEM entry starts at 0
  always_comb begin
    waitCnt_d  = waitCnt_q;
    busError_d = busError_q | timeout;
    if (state_d != state_q) begin
      waitCnt_d = 4'd0;
    end else if (waiting) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      waitCnt_q  <= 4'd0;
      busError_q <= 1'b0;
    end else begin
      waitCnt_q  <= waitCnt_d;
      busError_q <= busError_d;
    end
  end

  assign busError_o = busError_q;
`else
  logic [3:0] unusedTimeout;
  assign unusedTimeout = 4'(MEM_TIMEOUT);
  assign busError_o    = 1'b0;
`endif

  // Next state and all strobes; FETCH strobes and MEM exits are qualified by memReady_i
  always_comb begin
    state_d       = state_q;
    irWrite_o     = 1'b0;
    pcWrite_o     = 1'b0;
    pcSrc_o       = 2'd0;
    memRead_o     = 1'b0;
    memWrite_o    = 1'b0;
    memAddrSrc_o  = 1'b0;
    aluSrc_o      = 1'b0;
    aluOp_o       = 3'd0;
    writeEnable_o = 1'b0;
    regDest_o     = 2'd0;
    regData_o     = 2'd0;
    rsRd_o        = 2'd0;
    rsRt_o        = 1'b0;
    upperLower_o  = 1'b0;
    illegalOp_o   = 1'b0;
    halted_o      = 1'b0;

    case (state_q)
      S_START: state_d = S_FETCH;

      S_FETCH: begin
        memRead_o = 1'b1;
        if (memReady_i) begin
          irWrite_o = 1'b1;
          pcWrite_o = 1'b1;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        case (kindNow)
          K_LUI, K_JAL: state_d = S_WB;
          K_J: begin
            pcWrite_o = 1'b1;
            pcSrc_o   = 2'd2;
            state_d   = S_FETCH;
          end
          K_HALT: state_d = S_HALT;
          K_ILL: begin
            illegalOp_o = 1'b1;
            state_d     = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (kindQ)
          K_RTYPE: begin
            aluOp_o = opcode_q[2:0];
            state_d = S_WB;
          end
          K_ADDI: begin
            aluSrc_o = 1'b1;
            state_d  = S_WB;
          end
          K_LW, K_SW: begin
            aluSrc_o = 1'b1;
            state_d  = S_MEM;
          end
          K_BEQ: begin
            aluOp_o = 3'd1;
            if (zero_i) begin
              pcWrite_o = 1'b1;
              pcSrc_o   = 2'd1;
            end
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        memAddrSrc_o = 1'b1;
        memRead_o    = (kindQ == K_LW);
        memWrite_o   = (kindQ == K_SW);
        if (memReady_i) begin
          state_d = (kindQ == K_LW) ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        writeEnable_o = 1'b1;
        case (kindQ)
          K_ADDI: regDest_o = 2'd1;
          K_LW: begin
            regDest_o = 2'd1;
            regData_o = 2'd1;
          end
          K_LUI: begin
            regDest_o    = 2'd1;
            regData_o    = 2'd3;
            upperLower_o = 1'b1;
          end
          K_JAL: begin
            regDest_o = 2'd2;
            regData_o = 2'd2;
            pcWrite_o = 1'b1;
            pcSrc_o   = 2'd2;
          end
          default: begin
            regDest_o = 2'd0;
            regData_o = 2'd0;
          end
        endcase
        state_d = S_FETCH;
      end

      S_HALT: halted_o = 1'b1;

      default: state_d = S_START;
    endcase

`ifdef MEM_TIMEOUT_EN
    if (timeout) begin
      state_d = S_HALT;
    end
`endif
  end

endmodule
